// File: rtl/video_vga_double_if.sv
// TV-rate input side and VGA-rate output side of the scan doubler.
// The mixer drives the master modport and the doubler uses the slave modport.
`timescale 1ns/1ps
interface video_vga_double_if;
  logic [5:0] tv_color;
  logic       tv_pix_stb;
  logic       tv_line_stb;
  logic       tv_vsync;
  logic [5:0] vga_color;
  logic       vga_hsync;
  logic       vga_vsync;

  modport master (
    output tv_color, tv_pix_stb, tv_line_stb, tv_vsync,
    input  vga_color, vga_hsync, vga_vsync
  );

  modport slave (
    input  tv_color, tv_pix_stb, tv_line_stb, tv_vsync,
    output vga_color, vga_hsync, vga_vsync
  );
endinterface

// File: rtl/video_vga_double.sv
// VGA scan doubler: captures each TV line into a ping-pong buffer and replays
// the finished line twice at the 28MHz pixel rate, with a fresh hsync on each pass.
`timescale 1ns/1ps
module video_vga_double #(
  parameter int unsigned LINE_LEN   = 896,
  parameter int unsigned HSYNC_CLKS = 106,
  parameter int unsigned AW         = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  video_vga_double_if.slave     vid
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_PASS1 = 2'd1;
  localparam logic [1:0] ST_PASS2 = 2'd2;
  localparam logic [1:0] ST_HOLD  = 2'd3;

  localparam logic [AW-1:0] LEN    = AW'(LINE_LEN);
  localparam logic [AW-1:0] LAST   = AW'(LINE_LEN - 1);
  localparam logic [AW-1:0] HS_END = AW'(HSYNC_CLKS);

  logic [5:0]    mem_q [0:(1 << (AW + 1)) - 1];

  logic          wr_bank_q, wr_bank_d;
  logic [AW-1:0] wr_addr_q, wr_addr_d;
  logic          wr_en;
  logic [AW:0]   wr_idx;

  logic [1:0]    state_q, state_d;
  logic [AW-1:0] rd_addr_q, rd_addr_d;
  logic          rd_bank_q, rd_bank_d;
  logic          pass;

  logic [5:0]    rd_data_q;
  logic          act_q, hs_q, vs_samp_q, vs_q;
  logic [5:0]    color_q;
  logic          hsync_q, vsync_q;

  // Line strobe is resolved first so a coincident pixel lands at address 0 of the new bank.
  always_comb begin
    wr_bank_d = wr_bank_q;
    wr_addr_d = wr_addr_q;
    wr_en     = 1'b0;
    wr_idx    = {wr_bank_q, wr_addr_q};
    if (vid.tv_line_stb) begin
      wr_bank_d = ~wr_bank_q;
      wr_addr_d = '0;
    end
    if (vid.tv_pix_stb && (wr_addr_d < LEN)) begin
      wr_en     = 1'b1;
      wr_idx    = {wr_bank_d, wr_addr_d};
      wr_addr_d = wr_addr_d + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_bank_q <= 1'b0;
      wr_addr_q <= '0;
    end else begin
      wr_bank_q <= wr_bank_d;
      wr_addr_q <= wr_addr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en && !rst) begin
      mem_q[wr_idx] <= vid.tv_color;
    end
  end

  always_comb begin
    state_d   = state_q;
    rd_addr_d = rd_addr_q;
    rd_bank_d = rd_bank_q;
    if (vid.tv_line_stb) begin
      state_d   = ST_PASS1;
      rd_addr_d = '0;
      rd_bank_d = wr_bank_q;
    end else begin
      case (state_q)
        ST_PASS1: begin
          if (rd_addr_q == LAST) begin
            state_d   = ST_PASS2;
            rd_addr_d = '0;
          end else begin
            rd_addr_d = rd_addr_q + 1'b1;
          end
        end
        ST_PASS2: begin
          if (rd_addr_q == LAST) begin
            state_d   = ST_HOLD;
            rd_addr_d = '0;
          end else begin
            rd_addr_d = rd_addr_q + 1'b1;
          end
        end
        default: begin
          state_d = state_q;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      rd_addr_q <= '0;
      rd_bank_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      rd_addr_q <= rd_addr_d;
      rd_bank_q <= rd_bank_d;
    end
  end

  assign pass = (state_q == ST_PASS1) || (state_q == ST_PASS2);

  always_ff @(posedge clk) begin
    rd_data_q <= mem_q[{rd_bank_q, rd_addr_q}];
  end

  // Two-stage pipeline: RAM read, then output register; sync flags ride alongside.
  always_ff @(posedge clk) begin
    if (rst) begin
      act_q     <= 1'b0;
      hs_q      <= 1'b0;
      vs_samp_q <= 1'b0;
      vs_q      <= 1'b0;
      color_q   <= '0;
      hsync_q   <= 1'b0;
      vsync_q   <= 1'b0;
    end else begin
      act_q   <= pass;
      hs_q    <= pass && (rd_addr_q < HS_END);
      if (vid.tv_line_stb) begin
        vs_samp_q <= vid.tv_vsync;
      end
      vs_q    <= vs_samp_q;
      color_q <= act_q ? rd_data_q : '0;
      hsync_q <= hs_q;
      vsync_q <= vs_q;
    end
  end

  assign vid.vga_color = color_q;
  assign vid.vga_hsync = hsync_q;
  assign vid.vga_vsync = vsync_q;

endmodule
